// File: rtl/phase_sampler.sv
// Phase readout for the coupled oscillator array: resynchronises N oscillator
// outputs, counts per-oscillator mismatches against oscillator 0 over a window.
module phase_sampler #(
  parameter int          N              = 8,
  parameter int          SYNC_STAGES    = 2,
  parameter int          CNT_WIDTH      = 16,
  parameter logic [7:0]  READ_ADDR_MASK = 8'h03
) (
  input  logic                 clk,
  input  logic                 axi_rst,
  input  logic                 ising_rstn,
  input  logic [N-1:0]         osc_in,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] window,
  output logic                 busy,
  output logic                 done,
  output logic                 valid,
  output logic [N-1:0]         spins,
  input  logic [31:0]          rd_addr,
  output logic [31:0]          rdata
);

  // Handshake: start is a single-cycle request, honoured only in IDLE with
  // ising_rstn high; done pulses for exactly one cycle (RESOLVE) per result.
  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, SAMPLE = 2'd2, RESOLVE = 2'd3} state_t;

  localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] FLUSH_LAST = CNT_WIDTH'(SYNC_STAGES - 1);

  state_t               state, state_nxt;
  logic [N-1:0]         sync_q [SYNC_STAGES];
  logic [N-1:0]         s, x;
  logic [CNT_WIDTH-1:0] win, tick;
  logic [CNT_WIDTH-1:0] cnt [N];
  logic                 accept;
  logic [7:0]           idx;
  logic                 unused_addr;

  assign s      = sync_q[SYNC_STAGES-1];
  assign x      = s ^ {N{s[0]}};
  assign accept = (state == IDLE) && start && ising_rstn;
  assign done   = (state == RESOLVE);

  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= osc_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = FLUSH;
      FLUSH: begin
        if (!ising_rstn)              state_nxt = IDLE;
        else if (tick == FLUSH_LAST)  state_nxt = (win == '0) ? RESOLVE : SAMPLE;
      end
      SAMPLE: begin
        if (!ising_rstn)              state_nxt = IDLE;
        else if (tick == win - ONE)   state_nxt = RESOLVE;
      end
      RESOLVE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
      spins <= '0;
      win   <= '0;
      tick  <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            win   <= window;
            tick  <= '0;
            valid <= 1'b0;
            busy  <= 1'b1;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
          end
        end
        FLUSH: begin
          if (!ising_rstn)             busy <= 1'b0;
          else if (tick == FLUSH_LAST) tick <= '0;
          else                         tick <= tick + ONE;
        end
        SAMPLE: begin
          // An abort leaves the partial counts visible for debug reads.
          if (!ising_rstn) begin
            busy <= 1'b0;
          end else begin
            tick <= tick + ONE;
            for (int i = 0; i < N; i++)
              if (x[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + ONE;
          end
        end
        RESOLVE: begin
          // Strict majority: exactly half mismatching resolves to 0.
          for (int i = 0; i < N; i++) spins[i] <= (cnt[i] > (win >> 1));
          valid <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign idx         = rd_addr[9:2];
  assign unused_addr = ^{rd_addr[23:10], rd_addr[1:0]};

  always_comb begin
    rdata = 32'h0;
    if (rd_addr[31:24] == READ_ADDR_MASK) begin
      if (idx == 8'd0)      rdata = {29'b0, (state == IDLE), valid, busy};
      else if (idx == 8'd1) rdata = 32'(spins);
      else if (idx == 8'd2) rdata = 32'(win);
      else begin
        for (int i = 0; i < N; i++)
          if (idx == 8'(3 + i)) rdata = 32'(cnt[i]);
      end
    end
  end

endmodule

// File: tb/tb_phase_sampler.sv
// Bench for phase_sampler: square-wave oscillators with programmable phase
// offsets, an analytic mismatch model and an expected-result queue.
module tb_phase_sampler;
  localparam int N  = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          axi_rst, ising_rstn, start;
  logic [N-1:0]  osc_in;
  logic [15:0]   window;
  logic          busy, done, valid;
  logic [N-1:0]  spins;
  logic [31:0]   rd_addr, rdata;

  logic [N-1:0]  exp_spins_q[$];
  logic [15:0]   exp_cnt_q[$];
  logic [N-1:0]  last_spins;
  int            tests = 0;
  int            fails = 0;
  int unsigned   ph = 0;
  int            off[N];

  phase_sampler #(.N(N), .SYNC_STAGES(SS), .CNT_WIDTH(16), .READ_ADDR_MASK(8'h03)) dut (
    .clk(clk), .axi_rst(axi_rst), .ising_rstn(ising_rstn), .osc_in(osc_in),
    .start(start), .window(window), .busy(busy), .done(done), .valid(valid),
    .spins(spins), .rd_addr(rd_addr), .rdata(rdata)
  );

  // clock / oscillator generation
  always #5 clk = ~clk;

  always @(negedge clk) begin
    ph = ph + 1;
    for (int i = 0; i < N; i++) osc_in[i] = (((ph + off[i]) % 16) < 8);
  end

  // Square waves of period 16: relative offset d gives 2*min(d,16-d) mismatches per period.
  function automatic int model_cnt(input int d, input int win);
    int m;
    m = ((d % 16) + 16) % 16;
    if (m > 8) m = 16 - m;
    return (win / 16) * 2 * m;
  endfunction

  task automatic push_expected(input int win);
    logic [N-1:0] sp;
    int c;
    sp = '0;
    for (int i = 0; i < N; i++) begin
      c = model_cnt(off[i] - off[0], win);
      exp_cnt_q.push_back(16'(c));
      sp[i] = (c > win / 2);
    end
    exp_spins_q.push_back(sp);
  endtask

  task automatic read_reg(input logic [7:0] mask, input logic [7:0] idx, output logic [31:0] val);
    rd_addr = {mask, 14'b0, idx, 2'b00};
    #1 val = rdata;
  endtask

  // Pulses start and waits (bounded) for done; returns cycles from start to done.
  task automatic measure(input int win, input bit pulse_mid, output int cycles, output bit got);
    @(negedge clk);
    window = 16'(win);
    start  = 1'b1;
    cycles = 0;
    got    = 1'b0;
    for (int k = 0; k < win + 20; k++) begin
      @(negedge clk);
      cycles++;
      start = 1'b0;
      if (pulse_mid && cycles == 20) begin
        start  = 1'b1;
        window = 16'd5;
      end
      if (done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    axi_rst = 1'b1; ising_rstn = 1'b1; start = 1'b0; window = '0; rd_addr = '0;
    for (int i = 0; i < N; i++) off[i] = 0;
    repeat (3) @(negedge clk);
    tests++; if ({busy, done, valid} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {busy, done, valid}); end
    read_reg(8'h03, 8'd0, v);
    tests++; if (v !== 32'h4) begin fails++; $display("FAIL reset_status: got %0h expected 4", v); end
    read_reg(8'h03, 8'd1, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL reset_spins: got %0h expected 0", v); end
    read_reg(8'h03, 8'd2, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL reset_win: got %0h expected 0", v); end
    read_reg(8'h03, 8'd4, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL reset_cnt1: got %0h expected 0", v); end
    @(negedge clk);
    axi_rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_pattern(input string name, input int win);
    int cyc; bit got; logic [31:0] v; logic [N-1:0] es; logic [15:0] ec;
    push_expected(win);
    measure(win, 1'b0, cyc, got);
    tests++; if (!got || cyc != win + 1 + SS) begin fails++; $display("FAIL %s_latency: got %0d (done seen %0d) expected %0d", name, cyc, got, win + 1 + SS); end
    es = exp_spins_q.pop_front();
    @(negedge clk);
    tests++; if ({valid, busy} !== 2'b10) begin fails++; $display("FAIL %s_valid_busy: got %b expected 10", name, {valid, busy}); end
    tests++; if (spins !== es) begin fails++; $display("FAIL %s_spins: got %0h expected %0h", name, spins, es); end
    read_reg(8'h03, 8'd2, v);
    tests++; if (v !== 32'(win)) begin fails++; $display("FAIL %s_win: got %0d expected %0d", name, v, win); end
    for (int i = 0; i < N; i++) begin
      ec = exp_cnt_q.pop_front();
      read_reg(8'h03, 8'(3 + i), v);
      tests++; if (v !== 32'(ec)) begin fails++; $display("FAIL %s_cnt%0d: got %0d expected %0d", name, i, v, ec); end
    end
    last_spins = es;
  endtask

  task automatic test_abort();
    logic [31:0] v; int seen_done;
    for (int i = 0; i < N; i++) off[i] = (i == 0) ? 0 : 8;
    repeat (4) @(negedge clk);
    seen_done = 0;
    window = 16'd64;
    start  = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) seen_done++;
    end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
    ising_rstn = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy_after: got %b expected 0", busy); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    read_reg(8'h03, 8'd0, v);
    tests++; if (v !== 32'h4) begin fails++; $display("FAIL abort_status: got %0h expected 4", v); end
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    tests++; if (seen_done != 0) begin fails++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen_done); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL abort_valid: got %b expected 0", valid); end
    tests++; if (spins !== last_spins) begin fails++; $display("FAIL abort_spins_held: got %0h expected %0h", spins, last_spins); end
    read_reg(8'h03, 8'd4, v);
    tests++; if (v !== 32'd10) begin fails++; $display("FAIL abort_partial_cnt1: got %0d expected 10", v); end
    ising_rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ignored_start();
    int cyc; bit got; logic [31:0] v; logic [N-1:0] es;
    for (int i = 0; i < N; i++) off[i] = (i % 2) ? 8 : 0;
    repeat (4) @(negedge clk);
    push_expected(64);
    measure(64, 1'b1, cyc, got);
    tests++; if (!got || cyc != 64 + 1 + SS) begin fails++; $display("FAIL ignore_latency: got %0d (done seen %0d) expected %0d", cyc, got, 64 + 1 + SS); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    es = exp_spins_q.pop_front();
    for (int i = 0; i < N; i++) void'(exp_cnt_q.pop_front());
    read_reg(8'h03, 8'd0, v);
    tests++; if (v !== 32'h6) begin fails++; $display("FAIL ignore_status: got %0h expected 6", v); end
    read_reg(8'h03, 8'd2, v);
    tests++; if (v !== 32'd64) begin fails++; $display("FAIL ignore_win: got %0d expected 64", v); end
    tests++; if (spins !== es) begin fails++; $display("FAIL ignore_spins: got %0h expected %0h", spins, es); end
    @(negedge clk);
    tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL ignore_resolve_start: got %b expected 00", {busy, done}); end
    last_spins = es;
  endtask

  task automatic test_read_decode();
    logic [31:0] v;
    read_reg(8'h03, 8'(3 + N), v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL read_past_cnt: got %0h expected 0", v); end
    read_reg(8'h04, 8'd1, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL read_other_mask: got %0h expected 0", v); end
    read_reg(8'h03, 8'd1, v);
    tests++; if (v !== 32'(last_spins)) begin fails++; $display("FAIL read_spins: got %0h expected %0h", v, last_spins); end
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < N; i++) off[i] = (i % 2) ? 8 : 0;
    test_pattern("antiphase", 64);
    for (int i = 0; i < N; i++) off[i] = (i == 3) ? 4 : 0;
    test_pattern("quadrature", 64);
    for (int i = 0; i < N; i++) off[i] = (i % 2) ? 8 : 0;
    test_pattern("zero_window", 0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) off[i] = int'($urandom_range(0, 15));
      test_pattern("random", 16 * int'($urandom_range(1, 6)));
    end
    for (int i = 0; i < N; i++) off[i] = (i % 2) ? 8 : 0;
    test_pattern("antiphase2", 32);
    test_abort();
    test_ignored_start();
    test_read_decode();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
